// File: rtl/sdram_pkg.sv
// Shared definitions for the on-chip SDRAM user-port emulator:
// controller state encoding, default timing and byte-lane helpers.
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_REFRESH = 3'd4
  } state_t;

  localparam int DEFAULT_ADDR_DEPTH       = 24;
  localparam int DEFAULT_MEM_DEPTH        = 14;
  localparam int DEFAULT_RD_LATENCY       = 4;
  localparam int DEFAULT_WR_BUSY          = 2;
  localparam int DEFAULT_INIT_CYCLES      = 8;
  localparam int DEFAULT_REFRESH_INTERVAL = 335;
  localparam int DEFAULT_REFRESH_CYCLES   = 4;

  // Width of the phase and refresh counters; large enough for any
  // sensible timing parameter.
  localparam int CNT_W = 16;

  // Pick one byte lane out of a 16-bit storage word.
  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
    logic [7:0] res;
    if (lane) begin
      res = word[15:8];
    end else begin
      res = word[7:0];
    end
    return res;
  endfunction

  // Byte-enable pattern for a single-lane write.
  function automatic logic [1:0] lane_wen(input logic lane);
    logic [1:0] res;
    if (lane) begin
      res = 2'b10;
    end else begin
      res = 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/sdram_emu_mem.sv
// Backing store: 16-bit-word synchronous RAM with per-byte write enables
// and a registered read port. Contents are deliberately not reset so that
// data survives a controller reset, like a real SDRAM would.
module sdram_emu_mem
  import sdram_pkg::*;
#(
  parameter int WORD_AW = DEFAULT_MEM_DEPTH - 1
) (
  input  logic               clk,
  input  logic [1:0]         be,
  input  logic [WORD_AW-1:0] waddr,
  input  logic [15:0]        wdata,
  input  logic [WORD_AW-1:0] raddr,
  output logic [15:0]        rdata
);

  logic [15:0] mem_r [0:(1 << WORD_AW) - 1];
  logic [15:0] rdata_r;

  // Byte-lane writes and registered read of the storage array.
  always_ff @(posedge clk) begin
    if (be[0]) begin
      mem_r[waddr][7:0] <= wdata[7:0];
    end
    if (be[1]) begin
      mem_r[waddr][15:8] <= wdata[15:8];
    end
    rdata_r <= mem_r[raddr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sdram_byte_emu.sv
// On-chip responder for the SDRAM controller byte user port. Mimics the
// controller handshake (init delay, write busy time, read latency and
// periodic refresh stalls) on top of a small block RAM.
module sdram_byte_emu
  import sdram_pkg::*;
#(
  parameter int ADDR_DEPTH       = DEFAULT_ADDR_DEPTH,
  parameter int MEM_DEPTH        = DEFAULT_MEM_DEPTH,
  parameter int RD_LATENCY       = DEFAULT_RD_LATENCY,
  parameter int WR_BUSY          = DEFAULT_WR_BUSY,
  parameter int INIT_CYCLES      = DEFAULT_INIT_CYCLES,
  parameter int REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
  parameter int REFRESH_CYCLES   = DEFAULT_REFRESH_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data_wr,
  input  logic [ADDR_DEPTH-1:0] addr_in,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  rdy,
  output logic                  val,
  output logic [7:0]            data_rd
);

  // Terminal counts: a phase of N cycles ends on the edge where the
  // counter holds N-1.
  localparam logic [CNT_W-1:0] CNT_ZERO       = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] INIT_LAST      = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST        = CNT_W'(WR_BUSY - 1);
  localparam logic [CNT_W-1:0] RD_LAST        = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] REF_LAST       = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RFI_LAST       = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic             REFRESH_ENABLE = (REFRESH_INTERVAL != 0);

  state_t                 state_r, state_nxt_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0]       ref_cnt_r, ref_cnt_nxt_s;
  logic                   pend_r, pend_nxt_s;
  logic                   rdy_r, rdy_nxt_s;
  logic                   val_r, val_nxt_s;
  logic [7:0]             data_rd_r, data_rd_nxt_s;
  logic [MEM_DEPTH-1:0]   addr_r;
  logic                   wrap_s;
  logic                   accept_s, wr_acc_s, rd_acc_s;
  logic [1:0]             mem_be_s;
  logic [15:0]            mem_rdata_s;
  logic                   unused_addr_s;

  // Upper address bits only alias onto the backing store.
  assign unused_addr_s = ^addr_in[ADDR_DEPTH-1:MEM_DEPTH];

  // A write wins over a simultaneous read request.
  assign accept_s = rdy_r & (wr | rd);
  assign wr_acc_s = accept_s & wr;
  assign rd_acc_s = accept_s & ~wr & rd;

  assign mem_be_s = wr_acc_s ? lane_wen(addr_in[0]) : 2'b00;

  sdram_emu_mem #(
    .WORD_AW (MEM_DEPTH - 1)
  ) u_mem (
    .clk   (clk),
    .be    (mem_be_s),
    .waddr (addr_in[MEM_DEPTH-1:1]),
    .wdata ({data_wr, data_wr}),
    .raddr (addr_r[MEM_DEPTH-1:1]),
    .rdata (mem_rdata_s)
  );

  // Main sequencer: next state and phase counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    val_nxt_s   = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == INIT_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (pend_r) begin
          state_nxt_s = ST_REFRESH;
        end else if (wr_acc_s) begin
          state_nxt_s = ST_WRITE;
        end else if (rd_acc_s) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (cnt_r == WR_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_READ: begin
        if (cnt_r == RD_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
          val_nxt_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_REFRESH: begin
        if (cnt_r == REF_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Refresh timer, pending flag and the registered handshake outputs.
  always_comb begin
    wrap_s        = 1'b0;
    ref_cnt_nxt_s = ref_cnt_r;
    pend_nxt_s    = pend_r;
    if (REFRESH_ENABLE && (state_r != ST_INIT) && (ref_cnt_r == RFI_LAST)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
    if ((state_r == ST_INIT) || !REFRESH_ENABLE || wrap_s) begin
      ref_cnt_nxt_s = CNT_ZERO;
    end else begin
      ref_cnt_nxt_s = ref_cnt_r + CNT_ONE;
    end
    // A wrap while already pending simply leaves the flag set.
    if (wrap_s) begin
      pend_nxt_s = 1'b1;
    end else if ((state_r == ST_IDLE) && pend_r) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
    // rdy is registered from next-cycle values so a new pending refresh
    // closes the port on the very next cycle.
    rdy_nxt_s = (state_nxt_s == ST_IDLE) && !pend_nxt_s;
    if (val_nxt_s) begin
      data_rd_nxt_s = lane_byte(mem_rdata_s, addr_r[0]);
    end else begin
      data_rd_nxt_s = data_rd_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_INIT;
      cnt_r     <= CNT_ZERO;
      ref_cnt_r <= CNT_ZERO;
      pend_r    <= 1'b0;
      rdy_r     <= 1'b0;
      val_r     <= 1'b0;
      data_rd_r <= 8'h00;
      addr_r    <= {MEM_DEPTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      ref_cnt_r <= ref_cnt_nxt_s;
      pend_r    <= pend_nxt_s;
      rdy_r     <= rdy_nxt_s;
      val_r     <= val_nxt_s;
      data_rd_r <= data_rd_nxt_s;
      if (accept_s) begin
        addr_r <= addr_in[MEM_DEPTH-1:0];
      end
    end
  end

  assign rdy     = rdy_r;
  assign val     = val_r;
  assign data_rd = data_rd_r;

endmodule

// File: doc/sdram_byte_emu.md
SDRAM_BYTE_EMU -- requirements
Module: sdram_byte_emu

Interface
REQ-001 Parameter ADDR_DEPTH, 24, user byte-address width; identical to the SDRAM controller user port.
REQ-002 Parameter MEM_DEPTH, 14, backing-store byte-address bits; addr_in aliases modulo 2**MEM_DEPTH.
REQ-003 Parameter RD_LATENCY, 4, cycles from read accept to val (legal 2..15).
REQ-004 Parameter WR_BUSY, 2, cycles rdy stays low after write accept (legal 1..15).
REQ-005 Parameter INIT_CYCLES, 8, cycles after reset release before first rdy.
REQ-006 Parameter REFRESH_INTERVAL, 335, cycles between emulated refresh stalls; 0 disables refresh.
REQ-007 Parameter REFRESH_CYCLES, 4, length of each refresh stall.
REQ-008 clk  in  1  single clock, all logic rising-edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 data_wr  in  8  write byte.
REQ-011 addr_in  in  ADDR_DEPTH  byte address; bit 0 selects lane (0 = low byte, 1 = high byte).
REQ-012 wr  in  1  write request, held by requester until accepted.
REQ-013 rd  in  1  read request, held by requester until accepted.
REQ-014 rdy  out  1  high when a request is accepted at the next rising edge.
REQ-015 val  out  1  one-cycle pulse, data_rd valid.
REQ-016 data_rd  out  8  read byte.

Function
REQ-017 Block SHALL be a drop-in on-chip-memory responder for the SDRAM controller user port, for FPGA builds without SDRAM and for client benches.
REQ-018 Accept SHALL occur at a rising edge where rdy=1 and (wr|rd)=1; addr_in/data_wr SHALL be sampled at that edge only.
REQ-019 wr and rd both high at accept SHALL be a write; rd ignored.
REQ-020 States: INIT, IDLE, WRITE, READ, REFRESH; rdy=1 only in IDLE with no refresh pending.
REQ-021 INIT -> IDLE after INIT_CYCLES cycles; rdy first high INIT_CYCLES cycles after rst falls.
REQ-022 Write accept at edge N: IDLE -> WRITE; byte lane addr_in[0] of word addr_in[MEM_DEPTH-1:1] updated, other lane untouched; rdy low edges N+1..N+WR_BUSY, high again at N+WR_BUSY; a later read SHALL return the written byte.
REQ-023 Read accept at edge N: IDLE -> READ; val=1 for exactly the cycle after edge N+RD_LATENCY; rdy returns high in that same cycle.
REQ-024 data_rd SHALL hold its value until the next val; val SHALL never assert without a matching accepted read.
REQ-025 Refresh counter SHALL free-run from INIT exit, wrapping at REFRESH_INTERVAL, and set refresh pending on wrap.
REQ-026 Pending refresh SHALL drop rdy immediately, never abort a WRITE/READ in progress, enter REFRESH on next IDLE cycle, and stay there REFRESH_CYCLES cycles.
REQ-027 Pending refresh and request in the same IDLE cycle: refresh wins, request not accepted, requester holds it.
REQ-028 Counter SHALL keep counting during REFRESH and during operations; a second wrap while pending SHALL not queue an extra refresh.
REQ-029 addr_in bits above MEM_DEPTH SHALL be ignored (aliasing), no error.

Reset
REQ-030 Reset SHALL force: state INIT, rdy=0, val=0, data_rd=8'h00, counters 0, refresh pending 0.
REQ-031 Reset mid-READ SHALL suppress that val; memory contents SHALL NOT be cleared by reset.

Structure
REQ-032 Package sdram_pkg SHALL hold the state enum and default timing constants (RD_LATENCY, WR_BUSY, INIT_CYCLES, REFRESH_INTERVAL, REFRESH_CYCLES).
REQ-033 Sub-module sdram_emu_mem: synchronous 16-bit-word RAM, 2**(MEM_DEPTH-1) words, per-byte write enable, registered read.

Verification
REQ-034 Reset release, rd=1 held -> rdy first high after 8 cycles, accept, val 4 cycles later.
REQ-035 Write 0xA5 to 0x000010, then write 0x5A to 0x000011, read both -> 0xA5 and 0x5A (lane independence).
REQ-036 Write 0x3C to 0x004002, read 0x000002 with MEM_DEPTH=14 -> 0x3C (aliasing).
REQ-037 Request held across refresh wrap at cycle 335 -> rdy low 4+ cycles, no accept, request then accepted, data correct.
REQ-038 wr=rd=1 at 0x000020 with data 0x77 -> one write, no val; subsequent read returns 0x77.
REQ-039 Assert rst 2 cycles after read accept -> no val ever; data_rd 0x00; memory retains prior writes.
